// File: rtl/alu_issue.sv
// alu_issue: RV32I decode into ALU control/operands, held in a registered ID/EX slot with valid/ready
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_alu_ctrl,
  output logic [2:0]      out_br_type,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_illegal
);
  localparam logic [6:0] OP = 7'b0110011, OP_IMM = 7'b0010011, LOAD = 7'b0000011, STORE = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011, LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic is_shift, alt, f7_ok_op, f7_ok_imm;
  logic [3:0] alu_f;
  logic [XLEN-1:0] a_d, b_d, imm_d, sd_d, a_q, b_q, imm_q, sd_q;
  logic [3:0] ctrl_d, ctrl_q;
  logic [2:0] br_d, br_q;
  logic rw_d, ill_d, rw_q, ill_q, valid_q, valid_d, load;
  logic [4:0] rd_q;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign rd = instr[11:7];
  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign is_shift = (f3 == 3'b001) | (f3 == 3'b101);
  assign alt = f7[5] & ((op == OP) | (f3 == 3'b101));
  assign f7_ok_op = (f7 == 7'b0) | ((f7 == 7'b0100000) & ((f3 == 3'b000) | (f3 == 3'b101)));
  assign f7_ok_imm = ~is_shift | (f7 == 7'b0) | ((f7 == 7'b0100000) & (f3 == 3'b101));
  assign alu_f = f3 == 3'b000 ? (alt ? 4'b0001 : 4'b0000) :
                 f3 == 3'b001 ? 4'b1000 :
                 f3 == 3'b010 ? 4'b0101 :
                 f3 == 3'b011 ? 4'b1001 :
                 f3 == 3'b100 ? 4'b0100 :
                 f3 == 3'b101 ? (alt ? 4'b0111 : 4'b0110) :
                 f3 == 3'b110 ? 4'b0011 : 4'b0010;
  assign in_ready = ~valid_q | out_ready;
  assign load = in_valid & in_ready & ~flush;
  assign valid_d = ~flush & (load | (valid_q & ~out_ready));
  // decode the offered instruction into the slot's next contents
  always_comb begin
    a_d = '0;
    b_d = '0;
    ctrl_d = 4'b0000;
    br_d = 3'b000;
    imm_d = '0;
    rw_d = 1'b0;
    ill_d = 1'b0;
    sd_d = rs2_data;
    case (op)
      OP: begin
        a_d = rs1_data;
        b_d = is_shift ? {{(XLEN-5){1'b0}}, rs2_data[4:0]} : rs2_data;
        ctrl_d = alu_f;
        rw_d = 1'b1;
        ill_d = ~f7_ok_op;
      end
      OP_IMM: begin
        a_d = rs1_data;
        b_d = is_shift ? {{(XLEN-5){1'b0}}, instr[24:20]} : imm_i;
        ctrl_d = alu_f;
        rw_d = 1'b1;
        ill_d = ~f7_ok_imm;
      end
      LOAD: begin
        a_d = rs1_data;
        b_d = imm_i;
        imm_d = imm_i;
        rw_d = 1'b1;
      end
      STORE: begin
        a_d = rs1_data;
        b_d = imm_s;
        imm_d = imm_s;
      end
      BRANCH: begin
        a_d = rs1_data;
        b_d = rs2_data;
        ctrl_d = 4'b0001;
        imm_d = imm_b;
        br_d = f3[2] ? {1'b0, f3[1:0]} + 3'd3 : {2'b0, f3[0]} + 3'd1;
        ill_d = ~f3[2] & f3[1];
      end
      LUI: begin
        b_d = imm_u;
        rw_d = 1'b1;
      end
      AUIPC: begin
        a_d = pc;
        b_d = imm_u;
        rw_d = 1'b1;
      end
      JAL: begin
        a_d = pc;
        b_d = XLEN'(4);
        br_d = 3'b111;
        imm_d = imm_j;
        rw_d = 1'b1;
      end
      JALR: begin
        a_d = pc;
        b_d = XLEN'(4);
        br_d = 3'b111;
        imm_d = imm_i;
        rw_d = 1'b1;
        sd_d = rs1_data;
        ill_d = f3 != 3'b000;
      end
      default: ill_d = 1'b1;
    endcase
    ctrl_d = ill_d ? 4'b0000 : ctrl_d;
    br_d = ill_d ? 3'b000 : br_d;
    rw_d = rw_d & ~ill_d & (rd != 5'd0);
  end
  // slot register: valid follows the handshake, payload only changes on an accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      ctrl_q <= '0;
      br_q <= '0;
      imm_q <= '0;
      sd_q <= '0;
      rd_q <= '0;
      rw_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        a_q <= a_d;
        b_q <= b_d;
        ctrl_q <= ctrl_d;
        br_q <= br_d;
        imm_q <= imm_d;
        sd_q <= sd_d;
        rd_q <= rd;
        rw_q <= rw_d;
        ill_q <= ill_d;
      end
    end
  end
  assign out_valid = valid_q;
  assign out_a = a_q;
  assign out_b = b_q;
  assign out_alu_ctrl = ctrl_q;
  assign out_br_type = br_q;
  assign out_imm = imm_q;
  assign out_store_data = sd_q;
  assign out_rd = rd_q;
  assign out_reg_write = rw_q;
  assign out_illegal = ill_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed checks of decode, handshake, flush and async reset for alu_issue
module tb_alu_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b1;
  logic [31:0] instr = 32'h0, pc = 32'h0, rs1_data = 32'h0, rs2_data = 32'h0;
  logic [31:0] out_a, out_b, out_imm, out_store_data;
  logic [3:0] out_alu_ctrl;
  logic [2:0] out_br_type;
  logic [4:0] out_rd;
  logic out_reg_write, out_illegal;
  int passed = 0, total = 0;
  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_ctrl(out_alu_ctrl), .out_br_type(out_br_type), .out_imm(out_imm),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_a", out_a, 32'd0);
    chk("rst_ctrl", 32'(out_alu_ctrl), 32'd0);
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
    tick();
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_a", out_a, 32'd5);
    chk("add_b", out_b, 32'd7);
    chk("add_ctrl", 32'(out_alu_ctrl), 32'd0);
    chk("add_rd", 32'(out_rd), 32'd3);
    chk("add_rw", 32'(out_reg_write), 32'd1);
    instr = 32'h4030D093; rs1_data = 32'hF0000000;
    tick();
    chk("srai_ctrl", 32'(out_alu_ctrl), 32'h7);
    chk("srai_a", out_a, 32'hF0000000);
    chk("srai_b", out_b, 32'd3);
    chk("srai_rw", 32'(out_reg_write), 32'd1);
    instr = 32'h40208033; rs1_data = 32'd5;
    tick();
    chk("sub_ctrl", 32'(out_alu_ctrl), 32'h1);
    chk("sub_rw", 32'(out_reg_write), 32'd0);
    chk("sub_ill", 32'(out_illegal), 32'd0);
    instr = 32'h0020C463;
    tick();
    chk("blt_ctrl", 32'(out_alu_ctrl), 32'h1);
    chk("blt_br", 32'(out_br_type), 32'h3);
    chk("blt_imm", out_imm, 32'd8);
    chk("blt_rw", 32'(out_reg_write), 32'd0);
    instr = 32'h123452B7;
    tick();
    chk("lui_a", out_a, 32'd0);
    chk("lui_b", out_b, 32'h12345000);
    chk("lui_rd", 32'(out_rd), 32'd5);
    instr = 32'h0020A423; rs2_data = 32'hDEADBEEF;
    tick();
    chk("sw_b", out_b, 32'd8);
    chk("sw_rw", 32'(out_reg_write), 32'd0);
    chk("sw_sd", out_store_data, 32'hDEADBEEF);
    instr = 32'h02208033;
    tick();
    chk("badf7_ill", 32'(out_illegal), 32'd1);
    chk("badf7_ctrl", 32'(out_alu_ctrl), 32'd0);
    instr = 32'h010000EF; pc = 32'h100;
    tick();
    chk("jal_a", out_a, 32'h100);
    chk("jal_b", out_b, 32'd4);
    chk("jal_br", 32'(out_br_type), 32'h7);
    chk("jal_imm", out_imm, 32'd16);
    chk("jal_rw", 32'(out_reg_write), 32'd1);
    out_ready = 1'b0; instr = 32'h00100213;
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_a", out_a, 32'h100);
      chk("stall_rd", 32'(out_rd), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("release_rd", 32'(out_rd), 32'd4);
    chk("release_b", out_b, 32'd1);
    chk("release_valid", 32'(out_valid), 32'd1);
    rs1_data = 32'd0;
    for (int k = 1; k <= 8; k++) begin
      instr = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
      flush = (k == 4);
      tick();
      if (k == 4) begin
        chk("flush_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_rd", 32'(out_rd), 32'(k));
        chk("stream_b", out_b, 32'(k));
      end
    end
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; instr = 32'hFFFFFFFF;
    tick();
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_rw", 32'(out_reg_write), 32'd0);
    chk("ill_br", 32'(out_br_type), 32'd0);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("ill_hold", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ill", 32'(out_illegal), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
